// File: rtl/datapath_pkg.sv
// Shared types for the pipelined datapath: operation encodings, status flags
// and the control bundle carried from issue into execute.
package datapath_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    VSEL_C     = 2'b00,
    VSEL_PC    = 2'b01,
    VSEL_IMM8  = 2'b10,
    VSEL_MDATA = 2'b11
  } vsel_t;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } flags_t;

  typedef struct packed {
    alu_op_t alu_op;
    shift_t  shift;
    logic    bsel;
    vsel_t   vsel;
    logic    write_en;
    logic    load_status;
  } s1_ctrl_t;

endpackage

// File: rtl/datapath_regfile2r.sv
// NUM_REGS x DATA_WIDTH register file: two combinational read ports, one
// synchronous write port, cleared by synchronous reset.
module datapath_regfile2r #(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_REGS   = 8,
  localparam int RW         = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [RW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [RW-1:0]         raddr_a,
  input  logic [RW-1:0]         raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  // NOTE: the array is cleared on reset because software relies on all
  // registers starting at zero; this keeps it in flops rather than RAM.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/datapath_pipe.sv
// 3-stage (issue/read, execute, writeback) datapath with RAW hazard handling.
// Define DATAPATH_PIPE_FWD_EN for EX/WB forwarding; otherwise hazards stall issue.
module datapath_pipe
  import datapath_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_REGS   = 8,
  parameter  int PC_WIDTH   = 9,
  localparam int RW         = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RW-1:0]         rd,
  input  logic [RW-1:0]         rn,
  input  logic [RW-1:0]         rm,
  input  logic [1:0]            alu_op,
  input  logic [1:0]            shift,
  input  logic                  asel,
  input  logic                  bsel,
  input  logic [1:0]            vsel,
  input  logic                  write_en,
  input  logic                  load_status,
  input  logic [DATA_WIDTH-1:0] sximm5,
  input  logic [DATA_WIDTH-1:0] sximm8,
  input  logic [DATA_WIDTH-1:0] mdata,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] datapath_out,
  output logic                  Z_out,
  output logic                  N_out,
  output logic                  V_out
);

  localparam int MSB = DATA_WIDTH - 1;

  logic                  s1_valid_d, s1_valid_q;
  s1_ctrl_t              s1_ctrl_d, s1_ctrl_q;
  logic [RW-1:0]         s1_rd_d, s1_rd_q;
  logic [DATA_WIDTH-1:0] s1_a_d, s1_a_q, s1_b_d, s1_b_q, s1_imm5_d, s1_imm5_q;
  logic [DATA_WIDTH-1:0] s1_imm8_d, s1_imm8_q, s1_mdata_d, s1_mdata_q, s1_pc_d, s1_pc_q;

  logic                  s2_valid_d, s2_valid_q, s2_we_d, s2_we_q;
  vsel_t                 s2_vsel_d, s2_vsel_q;
  logic [RW-1:0]         s2_rd_d, s2_rd_q;
  logic [DATA_WIDTH-1:0] c_d, c_q, s2_imm8_d, s2_imm8_q, s2_mdata_d, s2_mdata_q, s2_pc_d, s2_pc_q;
  flags_t                flags_d, flags_q;

  logic [DATA_WIDTH-1:0] rf_rdata_a, rf_rdata_b, wb_value, opnd_a, opnd_b;
  logic [DATA_WIDTH-1:0] b_shift, b_alu, alu_res;
  flags_t                alu_flags;
  logic                  ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b, accept;
`ifdef DATAPATH_PIPE_FWD_EN
  logic [DATA_WIDTH-1:0] ex_value;
`endif

  datapath_regfile2r #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (s2_valid_q && s2_we_q),
    .waddr   (s2_rd_q),
    .wdata   (wb_value),
    .raddr_a (rn),
    .raddr_b (rm),
    .rdata_a (rf_rdata_a),
    .rdata_b (rf_rdata_b)
  );

  // Execute: shift B, select immediate, ALU and flag generation.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    b_shift = s1_b_q;
    case (s1_ctrl_q.shift)
      SH_LSL1: b_shift = s1_b_q << 1;
      SH_LSR1: b_shift = s1_b_q >> 1;
      SH_ASR1: b_shift = {s1_b_q[MSB], s1_b_q[MSB:1]};
      default: b_shift = s1_b_q;
    endcase
    b_alu       = s1_ctrl_q.bsel ? s1_imm5_q : b_shift;
    alu_res     = s1_a_q + b_alu;
    alu_flags.v = 1'b0;
    case (s1_ctrl_q.alu_op)
      ALU_ADD: begin
        alu_res     = s1_a_q + b_alu;
        alu_flags.v = (s1_a_q[MSB] == b_alu[MSB]) && (alu_res[MSB] != s1_a_q[MSB]);
      end
      ALU_SUB: begin
        alu_res     = s1_a_q - b_alu;
        alu_flags.v = (s1_a_q[MSB] != b_alu[MSB]) && (alu_res[MSB] != s1_a_q[MSB]);
      end
      ALU_AND: alu_res = s1_a_q & b_alu;
      default: alu_res = ~b_alu;
    endcase
    alu_flags.z = (alu_res == '0);
    alu_flags.n = alu_res[MSB];
  end

  always_comb begin
    wb_value = c_q;
    case (s2_vsel_q)
      VSEL_PC:    wb_value = s2_pc_q;
      VSEL_IMM8:  wb_value = s2_imm8_q;
      VSEL_MDATA: wb_value = s2_mdata_q;
      default:    wb_value = c_q;
    endcase
  end

  // Hazard detection against the EX and WB ops; EX is younger, so it wins.
  always_comb begin
    ex_hit_a = s1_valid_q && s1_ctrl_q.write_en && (s1_rd_q == rn) && !asel;
    ex_hit_b = s1_valid_q && s1_ctrl_q.write_en && (s1_rd_q == rm) && !bsel;
    wb_hit_a = s2_valid_q && s2_we_q && (s2_rd_q == rn) && !asel;
    wb_hit_b = s2_valid_q && s2_we_q && (s2_rd_q == rm) && !bsel;
`ifdef DATAPATH_PIPE_FWD_EN
    ex_value = alu_res;
    case (s1_ctrl_q.vsel)
      VSEL_PC:    ex_value = s1_pc_q;
      VSEL_IMM8:  ex_value = s1_imm8_q;
      VSEL_MDATA: ex_value = s1_mdata_q;
      default:    ex_value = alu_res;
    endcase
    in_ready = 1'b1;
    opnd_a   = ex_hit_a ? ex_value : (wb_hit_a ? wb_value : rf_rdata_a);
    opnd_b   = ex_hit_b ? ex_value : (wb_hit_b ? wb_value : rf_rdata_b);
`else
    in_ready = !(ex_hit_a || ex_hit_b || wb_hit_a || wb_hit_b);
    opnd_a   = rf_rdata_a;
    opnd_b   = rf_rdata_b;
`endif
  end

  always_comb begin
    accept     = in_valid && in_ready;
    s1_valid_d = accept;
    s1_ctrl_d  = s1_ctrl_q;
    s1_rd_d    = s1_rd_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_imm5_d  = s1_imm5_q;
    s1_imm8_d  = s1_imm8_q;
    s1_mdata_d = s1_mdata_q;
    s1_pc_d    = s1_pc_q;
    if (accept) begin
      s1_ctrl_d = '{alu_op: alu_op_t'(alu_op), shift: shift_t'(shift), bsel: bsel,
                    vsel: vsel_t'(vsel), write_en: write_en, load_status: load_status};
      s1_rd_d    = rd;
      s1_a_d     = asel ? '0 : opnd_a;
      s1_b_d     = opnd_b;
      s1_imm5_d  = sximm5;
      s1_imm8_d  = sximm8;
      s1_mdata_d = mdata;
      s1_pc_d    = DATA_WIDTH'(pc);
    end

    s2_valid_d = s1_valid_q;
    s2_we_d    = s2_we_q;
    s2_vsel_d  = s2_vsel_q;
    s2_rd_d    = s2_rd_q;
    c_d        = c_q;
    s2_imm8_d  = s2_imm8_q;
    s2_mdata_d = s2_mdata_q;
    s2_pc_d    = s2_pc_q;
    flags_d    = flags_q;
    if (s1_valid_q) begin
      s2_we_d    = s1_ctrl_q.write_en;
      s2_vsel_d  = s1_ctrl_q.vsel;
      s2_rd_d    = s1_rd_q;
      c_d        = alu_res;
      s2_imm8_d  = s1_imm8_q;
      s2_mdata_d = s1_mdata_q;
      s2_pc_d    = s1_pc_q;
      if (s1_ctrl_q.load_status) flags_d = alu_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_ctrl_q  <= '0;
      s1_rd_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_imm5_q  <= '0;
      s1_imm8_q  <= '0;
      s1_mdata_q <= '0;
      s1_pc_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_we_q    <= 1'b0;
      s2_vsel_q  <= VSEL_C;
      s2_rd_q    <= '0;
      c_q        <= '0;
      s2_imm8_q  <= '0;
      s2_mdata_q <= '0;
      s2_pc_q    <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ctrl_q  <= s1_ctrl_d;
      s1_rd_q    <= s1_rd_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_imm5_q  <= s1_imm5_d;
      s1_imm8_q  <= s1_imm8_d;
      s1_mdata_q <= s1_mdata_d;
      s1_pc_q    <= s1_pc_d;
      s2_valid_q <= s2_valid_d;
      s2_we_q    <= s2_we_d;
      s2_vsel_q  <= s2_vsel_d;
      s2_rd_q    <= s2_rd_d;
      c_q        <= c_d;
      s2_imm8_q  <= s2_imm8_d;
      s2_mdata_q <= s2_mdata_d;
      s2_pc_q    <= s2_pc_d;
      flags_q    <= flags_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign datapath_out = c_q;
  assign Z_out        = flags_q.z;
  assign N_out        = flags_q.n;
  assign V_out        = flags_q.v;

endmodule

// File: tb/tb_datapath_pipe.sv
// Scoreboard bench for datapath_pipe: an in-order architectural model predicts
// C and flags per op; a monitor compares them whenever out_valid is high.
module tb_datapath_pipe;

  localparam int V_C = 0, V_PC = 1, V_IMM8 = 2, V_MDATA = 3;
  localparam int A_ADD = 0, A_SUB = 1, A_AND = 2, A_NOT = 3;

  typedef struct {
    logic [2:0]  rd, rn, rm;
    logic [1:0]  alu, shift;
    logic        asel, bsel;
    logic [1:0]  vsel;
    logic        we, ls;
    logic [15:0] imm5, imm8, mdata;
    logic [8:0]  pc;
  } op_t;

  typedef struct packed {
    logic [15:0] c;
    logic [2:0]  flags;
  } exp_t;

  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready;
  logic [2:0]  rd = '0, rn = '0, rm = '0;
  logic [1:0]  alu_op = '0, shift = '0, vsel = '0;
  logic        asel = 1'b0, bsel = 1'b0, write_en = 1'b0, load_status = 1'b0;
  logic [15:0] sximm5 = '0, sximm8 = '0, mdata = '0;
  logic [8:0]  pc = '0;
  logic        out_valid, Z_out, N_out, V_out;
  logic [15:0] datapath_out;

  int   checks = 0, errors = 0;
  exp_t sb[$];
  int   m_regs[8];
  logic [2:0] m_flags;

  datapath_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rd(rd), .rn(rn), .rm(rm), .alu_op(alu_op), .shift(shift),
    .asel(asel), .bsel(bsel), .vsel(vsel), .write_en(write_en),
    .load_status(load_status), .sximm5(sximm5), .sximm8(sximm8),
    .mdata(mdata), .pc(pc), .out_valid(out_valid),
    .datapath_out(datapath_out), .Z_out(Z_out), .N_out(N_out), .V_out(V_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input int rd_i, rn_i, rm_i, alu_i, sh_i, asel_i, bsel_i,
                             vsel_i, we_i, ls_i, imm5_i, imm8_i);
    op_t o;
    o.rd = 3'(rd_i); o.rn = 3'(rn_i); o.rm = 3'(rm_i);
    o.alu = 2'(alu_i); o.shift = 2'(sh_i);
    o.asel = 1'(asel_i); o.bsel = 1'(bsel_i); o.vsel = 2'(vsel_i);
    o.we = 1'(we_i); o.ls = 1'(ls_i);
    o.imm5 = 16'(imm5_i); o.imm8 = 16'(imm8_i);
    o.mdata = 16'($urandom); o.pc = 9'($urandom);
    return o;
  endfunction

  // In-order architectural model: each op sees the results of all older ops.
  task automatic model_apply(input op_t o, output exp_t e);
    int a, b, r, sa, sb_i, sr;
    logic v;
    a = o.asel ? 0 : m_regs[o.rn];
    b = m_regs[o.rm];
    case (o.shift)
      2'd1: b = (b * 2) % 65536;
      2'd2: b = b / 2;
      2'd3: b = b / 2 + ((b >= 32768) ? 32768 : 0);
      default: ;
    endcase
    if (o.bsel) b = int'(o.imm5);
    sa   = (a >= 32768) ? a - 65536 : a;
    sb_i = (b >= 32768) ? b - 65536 : b;
    v = 1'b0;
    case (o.alu)
      2'd0: begin r = (a + b) % 65536; sr = sa + sb_i; v = (sr > 32767) || (sr < -32768); end
      2'd1: begin r = (a - b + 65536) % 65536; sr = sa - sb_i; v = (sr > 32767) || (sr < -32768); end
      2'd2: r = a & b;
      default: r = 65535 - b;
    endcase
    if (o.ls) m_flags = {r == 0, r >= 32768, v};
    e.c = 16'(r);
    e.flags = m_flags;
    if (o.we) begin
      case (o.vsel)
        2'd0: m_regs[o.rd] = r;
        2'd1: m_regs[o.rd] = int'(o.pc);
        2'd2: m_regs[o.rd] = int'(o.imm8);
        default: m_regs[o.rd] = int'(o.mdata);
      endcase
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_flags = 3'b000;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one op, waits for in_ready (bounded), returns the stall count.
  task automatic issue(input op_t o, output int stalls);
    exp_t e;
    rd = o.rd; rn = o.rn; rm = o.rm; alu_op = o.alu; shift = o.shift;
    asel = o.asel; bsel = o.bsel; vsel = o.vsel; write_en = o.we;
    load_status = o.ls; sximm5 = o.imm5; sximm8 = o.imm8; mdata = o.mdata; pc = o.pc;
    in_valid = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (!in_ready && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_apply(o, e);
    sb.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic readback(input int r, output int stalls);
    issue(mk(0, r, 0, A_ADD, 0, 0, 1, V_C, 0, 0, 0, 0), stalls);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("result_c", 32'(datapath_out), 32'(e.c));
          check("flags_znv", 32'({Z_out, N_out, V_out}), 32'(e.flags));
        end
      end
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int st, exp_st2, exp_st1;
    op_t o;
`ifdef DATAPATH_PIPE_FWD_EN
    exp_st2 = 0; exp_st1 = 0;
`else
    exp_st2 = 2; exp_st1 = 1;
`endif
    model_clear();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_datapath_out", 32'(datapath_out), 32'd0);
    check("rst_flags", 32'({Z_out, N_out, V_out}), 32'd0);

    issue(mk(0, 0, 0, A_ADD, 0, 1, 1, V_IMM8, 1, 0, 0, 5), st);
    issue(mk(1, 0, 0, A_ADD, 0, 1, 1, V_IMM8, 1, 0, 0, 7), st);
    idle(3);

    issue(mk(2, 0, 1, A_ADD, 0, 0, 0, V_C, 1, 0, 0, 0), st);
    issue(mk(3, 2, 2, A_ADD, 0, 0, 0, V_C, 1, 0, 0, 0), st);
    check("stall_back_to_back", 32'(st), 32'(exp_st2));
    readback(3, st);
    check("model_r3", 32'(m_regs[3]), 32'd24);

    issue(mk(0, 0, 0, A_ADD, 0, 1, 1, V_IMM8, 1, 0, 0, 16'h8000), st);
    issue(mk(6, 0, 0, A_SUB, 0, 0, 1, V_C, 1, 1, 1, 0), st);

    issue(mk(1, 0, 0, A_ADD, 0, 1, 1, V_IMM8, 1, 0, 0, 16'h8001), st);
    issue(mk(7, 0, 1, A_NOT, 3, 1, 0, V_C, 1, 1, 0, 0), st);

    issue(mk(4, 0, 0, A_ADD, 0, 1, 1, V_IMM8, 1, 0, 0, 1), st);
    issue(mk(4, 0, 0, A_ADD, 0, 1, 1, V_IMM8, 1, 0, 0, 2), st);
    readback(4, st);

    idle(3);
    issue(mk(6, 0, 0, A_ADD, 0, 1, 1, V_IMM8, 1, 0, 0, 3), st);
    idle(1);
    readback(6, st);
    check("stall_two_apart", 32'(st), 32'(exp_st1));

    issue(mk(7, 0, 0, A_ADD, 0, 1, 1, V_PC, 1, 0, 0, 0), st);
    issue(mk(5, 0, 0, A_ADD, 0, 1, 1, V_MDATA, 1, 0, 0, 0), st);
    readback(7, st);
    readback(5, st);

    repeat (300) begin
      o = mk($urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(3),
             $urandom_range(3), ($urandom_range(3) == 0) ? 1 : 0, ($urandom_range(3) == 0) ? 1 : 0,
             $urandom_range(3), ($urandom_range(3) != 0) ? 1 : 0, $urandom_range(1),
             int'($urandom_range(65535)), int'($urandom_range(65535)));
      issue(o, st);
      if ($urandom_range(3) == 0) idle($urandom_range(2));
    end

    // Reset while r5:=9 sits in EX: nothing may reach writeback or the flags.
    idle(3);
    issue(mk(5, 0, 0, A_ADD, 0, 1, 1, V_IMM8, 1, 1, 0, 9), st);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_datapath_out", 32'(datapath_out), 32'd0);
    check("rst_mid_flags", 32'({Z_out, N_out, V_out}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    if (sb.size() != 0) sb.delete(sb.size() - 1);
    model_clear();
    @(posedge clk);
    #1;
    check("rst_mid_out_valid_after", 32'(out_valid), 32'd0);
    readback(5, st);

    idle(6);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
